// File: rtl/fpm_pkg.sv
// fpm_pkg: shared types and helpers for the F-PM phase sequencer.
//   phase_e    - sequencer phases, including the IDLE and END bookends
//   op_cls_e   - op classes; ops within a class walk identical phase sequences
//   OP_*       - ir[7:9] op code values
//   op_class() - maps {nrf, ir} to an op class
//   is_loop_phase() - phases that may repeat and are guarded by the watchdog
package fpm_pkg;

    localparam int CNT_W = 6;

    typedef enum logic [3:0] {
        IDLE, F2, F4, F5, F6, F7, F8, F9, F10, F13, END
    } phase_e;

    typedef enum logic [2:0] {
        CLS_ADD,   // AD, SD
        CLS_FADD,  // AF, SF
        CLS_MUL,   // MW, DW
        CLS_FMUL,  // MF, DF
        CLS_NRF    // normalize only
    } op_cls_e;

    localparam logic [2:0] OP_AD = 3'd0;
    localparam logic [2:0] OP_SD = 3'd1;
    localparam logic [2:0] OP_MW = 3'd2;
    localparam logic [2:0] OP_DW = 3'd3;
    localparam logic [2:0] OP_AF = 3'd4;
    localparam logic [2:0] OP_SF = 3'd5;
    localparam logic [2:0] OP_MF = 3'd6;
    localparam logic [2:0] OP_DF = 3'd7;

    // nrf overrides whatever op code is on ir.
    function automatic op_cls_e op_class(input logic [2:0] ir, input logic nrf);
        op_cls_e cls;
        if (nrf) begin
            cls = CLS_NRF;
        end else begin
            case (ir)
                OP_AD, OP_SD: cls = CLS_ADD;
                OP_AF, OP_SF: cls = CLS_FADD;
                OP_MW, OP_DW: cls = CLS_MUL;
                default:      cls = CLS_FMUL;
            endcase
        end
        return cls;
    endfunction

    function automatic logic is_loop_phase(input phase_e p);
        return (p == F8) || (p == F9) || (p == F10);
    endfunction

endpackage

// File: rtl/fpm_loopcnt.sv
// fpm_loopcnt: iteration watchdog for the F8/F9/F10 loops.
//   __clk, rst_ : clock, synchronous active-low reset
//   clr         : zero the count (wins over inc)
//   inc         : one loop iteration completes this cycle
//   limit       : iteration budget
//   hit         : the iteration completing now brings the count to limit
module fpm_loopcnt
    import fpm_pkg::*;
(
    input  logic             __clk,
    input  logic             rst_,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             hit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_nxt;

    // Count as it will stand once the current iteration is included.
    assign cnt_nxt = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign hit     = inc && (cnt_nxt >= {1'b0, limit});

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_nxt[CNT_W-1:0];
        end
    end

    always_ff @(posedge __clk) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fpm_seq.sv
// fpm_seq: phase sequencer for the F-PM microoperation datapath.
// Accepts one FPU/AWP op per start and walks the F-PM phase lines, two cycles
// per phase (S1 carries strob_fp, S2 carries strob2_fp), branching on
// datapath flags sampled in S2.
//   __clk, rst_          : clock, synchronous active-low reset
//   start, ir, pufa, nrf : op request, op code, AWP-op qualifier, normalize-only
//   g, fic_zero, nz, ws  : datapath branch flags
//   fi_any               : FP exception raised, aborts the op
//   f2_..f10_ (low), f9, f13 (high) : phase lines
//   strob_fp, strob2_fp  : first / second strobe of the current phase
//   busy, done           : op in progress, one-cycle end pulse
//   err, abrt            : watchdog / exception abort, held until next start
// Every output is a flop loaded from the next-state decode.
module fpm_seq
    import fpm_pkg::*;
#(
    parameter int MAX_LOOP = 48
) (
    input  logic       __clk,
    input  logic       rst_,
    input  logic       start,
    input  logic [2:0] ir,
    input  logic       pufa,
    input  logic       nrf,
    input  logic       g,
    input  logic       fic_zero,
    input  logic       nz,
    input  logic       ws,
    input  logic       fi_any,
    output logic       f2_,
    output logic       f4_,
    output logic       f5_,
    output logic       f6_,
    output logic       f7_,
    output logic       f8_,
    output logic       f10_,
    output logic       f9,
    output logic       f13,
    output logic       strob_fp,
    output logic       strob2_fp,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       abrt
);

    localparam logic [CNT_W-1:0] LOOP_LIMIT = CNT_W'(MAX_LOOP);

    phase_e  phase_q, phase_d;
    op_cls_e cls_q, cls_d;
    logic    s2_q, s2_d;
    logic    corr_done_q, corr_done_d;
    logic    bypass_q, bypass_d;
    logic    err_q, err_d;
    logic    abrt_q, abrt_d;

    logic f2_q, f4_q, f5_q, f6_q, f7_q, f8_q, f10_q, f9_q, f13_q;
    logic f2_d, f4_d, f5_d, f6_d, f7_d, f8_d, f10_d, f9_d, f13_d;
    logic strob_q, strob2_q, busy_q, done_q;
    logic strob_d, strob2_d, busy_d, done_d;

    phase_e nxt;
    logic   stay;
    logic   in_phase;
    logic   lc_clr, lc_inc, lc_hit;

    // Watchdog: counts S2s of a loop phase, restarts whenever the phase changes.
    assign lc_inc = s2_q && is_loop_phase(phase_q);
    assign lc_clr = (phase_d != phase_q);

    fpm_loopcnt u_loopcnt (
        .__clk (__clk),
        .rst_  (rst_),
        .clr   (lc_clr),
        .inc   (lc_inc),
        .limit (LOOP_LIMIT),
        .hit   (lc_hit)
    );

    // Next-state logic
    always_comb begin
        phase_d     = phase_q;
        s2_d        = s2_q;
        cls_d       = cls_q;
        corr_done_d = corr_done_q;
        bypass_d    = bypass_q;
        err_d       = err_q;
        abrt_d      = abrt_q;
        nxt         = END;
        stay        = 1'b0;

        case (phase_q)
            IDLE: begin
                if (start && (pufa || nrf)) begin
                    cls_d       = op_class(ir, nrf);
                    phase_d     = (op_class(ir, nrf) == CLS_ADD) ? F6 : F2;
                    s2_d        = 1'b0;
                    corr_done_d = 1'b0;
                    bypass_d    = 1'b0;
                    err_d       = 1'b0;
                    abrt_d      = 1'b0;
                end
            end
            END: begin
                phase_d = IDLE;
            end
            default: begin
                if (!s2_q) begin
                    s2_d = 1'b1;
                end else begin
                    s2_d = 1'b0;
                    case (phase_q)
                        F2: begin
                            case (cls_q)
                                CLS_FADD: nxt = F5;
                                CLS_NRF:  nxt = F10;
                                default:  nxt = F4;
                            endcase
                        end
                        F4: nxt = F9;
                        F5: begin
                            nxt      = g ? F6 : F8;
                            bypass_d = g;
                        end
                        F8: begin
                            stay = !fic_zero;
                            nxt  = F6;
                        end
                        F9: begin
                            stay = !fic_zero;
                            nxt  = (cls_q == CLS_MUL) ? F6 : F10;
                        end
                        F10: begin
                            stay = nz;
                            if ((cls_q != CLS_NRF) && ws && !corr_done_q) begin
                                nxt = F7;
                            end else begin
                                nxt = F13;
                            end
                        end
                        F6: begin
                            case (cls_q)
                                CLS_ADD: nxt = F7;
                                CLS_MUL: nxt = END;
                                default: begin
                                    // On the g path F6 runs twice: once standing
                                    // in for the skipped alignment loop, once as
                                    // the regular post-alignment F6.
                                    if (bypass_q) begin
                                        nxt      = F6;
                                        bypass_d = 1'b0;
                                    end else begin
                                        nxt = F7;
                                    end
                                end
                            endcase
                        end
                        F7: begin
                            if (cls_q == CLS_ADD) begin
                                nxt = END;
                            end else begin
                                // F7 before F10 (add path) vs. the one-shot
                                // correction F7 after F10.
                                nxt = corr_done_q ? F13 : F10;
                            end
                        end
                        default: nxt = END;
                    endcase

                    // Exception beats watchdog beats normal loop exit.
                    if (fi_any) begin
                        abrt_d  = 1'b1;
                        phase_d = END;
                    end else if (stay && lc_hit) begin
                        err_d   = 1'b1;
                        phase_d = END;
                    end else if (stay) begin
                        phase_d = phase_q;
                    end else begin
                        phase_d = nxt;
                    end

                    if ((phase_q == F10) && (phase_d == F7)) begin
                        corr_done_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Output decode from the next state
    always_comb begin
        f2_d     = (phase_d != F2);
        f4_d     = (phase_d != F4);
        f5_d     = (phase_d != F5);
        f6_d     = (phase_d != F6);
        f7_d     = (phase_d != F7);
        f8_d     = (phase_d != F8);
        f10_d    = (phase_d != F10);
        f9_d     = (phase_d == F9);
        f13_d    = (phase_d == F13);
        in_phase = (phase_d != IDLE) && (phase_d != END);
        strob_d  = in_phase && !s2_d;
        strob2_d = in_phase && s2_d;
        busy_d   = (phase_d != IDLE);
        done_d   = (phase_d == END);
    end

    always_ff @(posedge __clk) begin
        if (!rst_) begin
            phase_q     <= IDLE;
            s2_q        <= 1'b0;
            cls_q       <= CLS_ADD;
            corr_done_q <= 1'b0;
            bypass_q    <= 1'b0;
            err_q       <= 1'b0;
            abrt_q      <= 1'b0;
            f2_q        <= 1'b1;
            f4_q        <= 1'b1;
            f5_q        <= 1'b1;
            f6_q        <= 1'b1;
            f7_q        <= 1'b1;
            f8_q        <= 1'b1;
            f10_q       <= 1'b1;
            f9_q        <= 1'b0;
            f13_q       <= 1'b0;
            strob_q     <= 1'b0;
            strob2_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            s2_q        <= s2_d;
            cls_q       <= cls_d;
            corr_done_q <= corr_done_d;
            bypass_q    <= bypass_d;
            err_q       <= err_d;
            abrt_q      <= abrt_d;
            f2_q        <= f2_d;
            f4_q        <= f4_d;
            f5_q        <= f5_d;
            f6_q        <= f6_d;
            f7_q        <= f7_d;
            f8_q        <= f8_d;
            f10_q       <= f10_d;
            f9_q        <= f9_d;
            f13_q       <= f13_d;
            strob_q     <= strob_d;
            strob2_q    <= strob2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign f2_       = f2_q;
    assign f4_       = f4_q;
    assign f5_       = f5_q;
    assign f6_       = f6_q;
    assign f7_       = f7_q;
    assign f8_       = f8_q;
    assign f10_      = f10_q;
    assign f9        = f9_q;
    assign f13       = f13_q;
    assign strob_fp  = strob_q;
    assign strob2_fp = strob2_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign abrt      = abrt_q;

endmodule

// File: tb/tb_fpm_seq.sv
// Scoreboard bench for fpm_seq: stimulus queues expected phase/done events
// with their cycle numbers; a negedge monitor pops and compares them and
// checks per-cycle strobe/phase-line invariants.
module tb_fpm_seq;

    localparam logic [8:0] P_F2  = 9'h100;
    localparam logic [8:0] P_F4  = 9'h080;
    localparam logic [8:0] P_F5  = 9'h040;
    localparam logic [8:0] P_F6  = 9'h020;
    localparam logic [8:0] P_F7  = 9'h010;
    localparam logic [8:0] P_F8  = 9'h008;
    localparam logic [8:0] P_F9  = 9'h004;
    localparam logic [8:0] P_F10 = 9'h002;
    localparam logic [8:0] P_F13 = 9'h001;
    localparam logic [14:0] RESET_OUT = 15'h7F00;

    logic clk = 1'b0;
    logic rst_, start, pufa, nrf, g, fic_zero, nz, ws, fi_any;
    logic [2:0] ir;
    logic f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13;
    logic strob_fp, strob2_fp, busy, done, err, abrt;

    logic [8:0]  ph_vec;
    logic [14:0] out_vec;

    typedef struct {
        int         cyc;
        logic [8:0] ph;
        logic       is_done;
        logic       err;
        logic       abrt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   c0;
    logic mon_en = 1'b0;
    logic prev_s1 = 1'b0;
    logic prev_done = 1'b0;
    logic [8:0] prev_ph = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ph_vec  = {~f2_, ~f4_, ~f5_, ~f6_, ~f7_, ~f8_, f9, ~f10_, f13};
    assign out_vec = {f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13,
                      strob_fp, strob2_fp, busy, done, err, abrt};

    fpm_seq #(.MAX_LOOP(48)) dut (
        .__clk     (clk),
        .rst_      (rst_),
        .start     (start),
        .ir        (ir),
        .pufa      (pufa),
        .nrf       (nrf),
        .g         (g),
        .fic_zero  (fic_zero),
        .nz        (nz),
        .ws        (ws),
        .fi_any    (fi_any),
        .f2_       (f2_),
        .f4_       (f4_),
        .f5_       (f5_),
        .f6_       (f6_),
        .f7_       (f7_),
        .f8_       (f8_),
        .f10_      (f10_),
        .f9        (f9),
        .f13       (f13),
        .strob_fp  (strob_fp),
        .strob2_fp (strob2_fp),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .abrt      (abrt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_ph(input int c, input logic [8:0] p);
        ev_t e;
        e.cyc = c; e.ph = p; e.is_done = 1'b0; e.err = 1'b0; e.abrt = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int c, input logic e_err, input logic e_abrt);
        ev_t e;
        e.cyc = c; e.ph = '0; e.is_done = 1'b1; e.err = e_err; e.abrt = e_abrt;
        exp_q.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            chk("one_phase_line", 32'($countones(ph_vec) <= 1), 32'd1);
            chk("strobe_exclusive", 32'(strob_fp & strob2_fp), 32'd0);
            chk("busy_decode", 32'(busy), 32'((ph_vec != 0) || done));
            chk("s2_follows_s1", 32'(strob2_fp), 32'(prev_s1));
            chk("strobe_has_phase", 32'((strob_fp | strob2_fp) && (ph_vec == 0)), 32'd0);
            if (prev_s1) chk("s2_same_phase", 32'(ph_vec), 32'(prev_ph));
            if (prev_done) chk("idle_after_done", 32'(busy), 32'd0);
            if (strob_fp || done) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_event: got ph=%0h done=%0b at cycle %0d, expected none",
                             ph_vec, done, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", 32'(done), 32'(mon_e.is_done));
                    chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                    if (mon_e.is_done) begin
                        chk("done_err", 32'(err), 32'(mon_e.err));
                        chk("done_abrt", 32'(abrt), 32'(mon_e.abrt));
                    end else begin
                        chk("event_phase", 32'(ph_vec), 32'(mon_e.ph));
                    end
                end
            end
        end
        prev_s1   = strob_fp && rst_;
        prev_done = done && rst_;
        prev_ph   = ph_vec;
    end

    initial begin
        rst_ = 1'b0; start = 1'b0; ir = 3'd0; pufa = 1'b0; nrf = 1'b0;
        g = 1'b0; fic_zero = 1'b1; nz = 1'b0; ws = 1'b0; fi_any = 1'b0;
        tick(); tick();
        chk("reset_outputs", 32'(out_vec), 32'(RESET_OUT));
        rst_ = 1'b1; mon_en = 1'b1;
        tick();

        // AD with start held through the op (ignored while busy), then SD back-to-back
        c0 = cyc; start = 1'b1; pufa = 1'b1; ir = 3'd0;
        exp_ph(c0 + 1, P_F6); exp_ph(c0 + 3, P_F7); exp_done(c0 + 5, 1'b0, 1'b0);
        exp_ph(c0 + 7, P_F6); exp_ph(c0 + 9, P_F7); exp_done(c0 + 11, 1'b0, 1'b0);
        wait_to(c0 + 6); ir = 3'd1;
        wait_to(c0 + 7); start = 1'b0;
        wait_to(c0 + 13);

        // AF, g=1: F6 stands in for alignment, then the regular F6
        c0 = cyc; ir = 3'd4; g = 1'b1; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F5); exp_ph(c0 + 5, P_F6);
        exp_ph(c0 + 7, P_F6); exp_ph(c0 + 9, P_F7); exp_ph(c0 + 11, P_F10);
        exp_ph(c0 + 13, P_F13); exp_done(c0 + 15, 1'b0, 1'b0);
        tick(); start = 1'b0;
        wait_to(c0 + 17); g = 1'b0;

        // SF, g=0: fic_zero rises at the third F8 S2
        c0 = cyc; ir = 3'd5; fic_zero = 1'b0; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F5);
        exp_ph(c0 + 5, P_F8); exp_ph(c0 + 7, P_F8); exp_ph(c0 + 9, P_F8);
        exp_ph(c0 + 11, P_F6); exp_ph(c0 + 13, P_F7); exp_ph(c0 + 15, P_F10);
        exp_ph(c0 + 17, P_F13); exp_done(c0 + 19, 1'b0, 1'b0);
        tick(); start = 1'b0;
        wait_to(c0 + 10); fic_zero = 1'b1;
        wait_to(c0 + 21);

        // MF, fic_zero stuck at 0: 48 F9 passes, watchdog abort
        c0 = cyc; ir = 3'd6; fic_zero = 1'b0; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F4);
        for (int k = 0; k < 48; k++) exp_ph(c0 + 5 + 2 * k, P_F9);
        exp_done(c0 + 101, 1'b1, 1'b0);
        tick(); start = 1'b0;
        wait_to(c0 + 105); fic_zero = 1'b1;
        chk("err_held", 32'(err), 32'd1);
        chk("abrt_quiet", 32'(abrt), 32'd0);

        // DF: F10 passes twice (nz), ws triggers one correction F7
        c0 = cyc; ir = 3'd7; nz = 1'b1; ws = 1'b1; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F4); exp_ph(c0 + 5, P_F9);
        exp_ph(c0 + 7, P_F10); exp_ph(c0 + 9, P_F10); exp_ph(c0 + 11, P_F7);
        exp_ph(c0 + 13, P_F13); exp_done(c0 + 15, 1'b0, 1'b0);
        tick(); start = 1'b0;
        chk("err_cleared_c1", 32'(err), 32'd0);
        wait_to(c0 + 9); nz = 1'b0;
        wait_to(c0 + 17); ws = 1'b0;

        // DW, exception at F4 S2
        c0 = cyc; ir = 3'd3; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F4); exp_done(c0 + 5, 1'b0, 1'b1);
        tick(); start = 1'b0;
        wait_to(c0 + 4); fi_any = 1'b1;
        tick(); fi_any = 1'b0;
        wait_to(c0 + 8);
        chk("abrt_held", 32'(abrt), 32'd1);

        // NRF overriding a pufa AD op
        c0 = cyc; ir = 3'd0; nrf = 1'b1; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F10); exp_ph(c0 + 5, P_F13);
        exp_done(c0 + 7, 1'b0, 1'b0);
        tick(); start = 1'b0; nrf = 1'b0;
        chk("abrt_cleared_c1", 32'(abrt), 32'd0);
        wait_to(c0 + 9);

        // Unqualified request is ignored
        pufa = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        chk("ignored_req_busy", 32'(busy), 32'd0);
        pufa = 1'b1;
        tick();

        // Reset during F8 S1, then a normal AD
        c0 = cyc; ir = 3'd4; g = 1'b0; fic_zero = 1'b0; start = 1'b1;
        exp_ph(c0 + 1, P_F2); exp_ph(c0 + 3, P_F5); exp_ph(c0 + 5, P_F8);
        tick(); start = 1'b0;
        wait_to(c0 + 5); rst_ = 1'b0;
        tick();
        chk("midop_reset_outputs", 32'(out_vec), 32'(RESET_OUT));
        rst_ = 1'b1; fic_zero = 1'b1;
        tick();
        c0 = cyc; ir = 3'd0; start = 1'b1;
        exp_ph(c0 + 1, P_F6); exp_ph(c0 + 3, P_F7); exp_done(c0 + 5, 1'b0, 1'b0);
        tick(); start = 1'b0;
        wait_to(c0 + 8);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
